fifo_pointer_ctrl: RTL and testbench

Pointer, occupancy and arbitration controller for the FIFO read memory in the sample-buffer path. Converts push/pop requests from the producer and consumer into the memory's `write_en`, `read_en`, `wraddr`, `rdaddr`, `fifofull` and `notempty` inputs. Tracks occupancy and generates an almost-full watermark and a read-data-valid strobe aligned to the memory's registered `read_data`. Sits directly upstream of the memory and drives all of its control pins.

---
 rtl/fifo_pointer_ctrl.sv | 113 +++++++++++
 tb/tb_fifo_pointer_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pointer_ctrl.sv
// Pointer, occupancy and arbitration controller for the sample-buffer FIFO memory.
// Optional sticky overflow/underflow flags are built only when FIFO_CTRL_ERRFLAG_EN is defined.
module fifo_pointer_ctrl #(
    parameter int ADDRBIT    = 5,
    parameter int FIFO_DEPTH = 32,
    parameter int AFULL_LVL  = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fifo_en,
    input  logic               clear,
    input  logic               push_req,
    input  logic               pop_req,
    output logic               write_en,
    output logic               read_en,
    output logic [ADDRBIT-1:0] wraddr,
    output logic [ADDRBIT-1:0] rdaddr,
    output logic               fifofull,
    output logic               notempty,
    output logic [ADDRBIT:0]   count,
    output logic               almost_full,
    output logic               rd_valid,
    output logic               overflow,
    output logic               underflow
);

    localparam int CW = ADDRBIT + 1;
    localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0]      DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]      AFULL_CNT = CW'(AFULL_LVL);

    logic [ADDRBIT-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRBIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, nempty_q, afull_q, rd_valid_q;

    // Handshake: push_req/pop_req are level requests held by the requester;
    // write_en/read_en are the acknowledges, and a request is consumed only in
    // a cycle where its enable is high. Write wins over a simultaneous read.
    // Both enables are forced low while rst_n is asserted.
    assign write_en = rst_n & fifo_en & push_req & ~full_q & ~clear;
    assign read_en  = rst_n & fifo_en & pop_req & nempty_q & ~write_en & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (write_en) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end else if (read_en) begin
            rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
    end

    // Flags are registered from the next count so they always match the count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            nempty_q   <= 1'b0;
            afull_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_CNT);
            nempty_q   <= (count_d != '0);
            afull_q    <= (count_d >= AFULL_CNT);
            rd_valid_q <= read_en;
        end
    end

`ifdef FIFO_CTRL_ERRFLAG_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (clear) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (fifo_en & push_req & full_q) ovf_q <= 1'b1;
            if (fifo_en & pop_req & ~nempty_q) udf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign wraddr      = wr_ptr_q;
    assign rdaddr      = rd_ptr_q;
    assign count       = count_q;
    assign fifofull    = full_q;
    assign notempty    = nempty_q;
    assign almost_full = afull_q;
    assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_fifo_pointer_ctrl.sv
// Directed bench for fifo_pointer_ctrl: main instance at depth 32, second instance at depth 24 for wrap.
module tb_fifo_pointer_ctrl;

`ifdef FIFO_CTRL_ERRFLAG_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_en, clear, push_req, pop_req;
    logic [11:0] wdata;
    logic        write_en, read_en, fifofull, notempty, almost_full, rd_valid, overflow, underflow;
    logic [4:0]  wraddr, rdaddr;
    logic [5:0]  count;

    logic        w_en, w_clear, w_push, w_pop;
    logic [11:0] w_wdata;
    logic        w_we, w_re, w_full, w_nempty, w_afull, w_rdv, w_ovf, w_udf;
    logic [4:0]  w_wraddr, w_rdaddr;
    logic [5:0]  w_count;

    logic [11:0] mem [0:31];
    logic [11:0] rdata;
    logic [11:0] mem2 [0:23];
    logic [11:0] rdata2;

    logic [11:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_rdv = 0;

    always #5 clk = ~clk;

    fifo_pointer_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .fifo_en(fifo_en), .clear(clear),
        .push_req(push_req), .pop_req(pop_req), .write_en(write_en), .read_en(read_en),
        .wraddr(wraddr), .rdaddr(rdaddr), .fifofull(fifofull), .notempty(notempty),
        .count(count), .almost_full(almost_full), .rd_valid(rd_valid),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_pointer_ctrl #(.ADDRBIT(5), .FIFO_DEPTH(24), .AFULL_LVL(20)) u_wrap (
        .clk(clk), .rst_n(rst_n), .fifo_en(w_en), .clear(w_clear),
        .push_req(w_push), .pop_req(w_pop), .write_en(w_we), .read_en(w_re),
        .wraddr(w_wraddr), .rdaddr(w_rdaddr), .fifofull(w_full), .notempty(w_nempty),
        .count(w_count), .almost_full(w_afull), .rd_valid(w_rdv),
        .overflow(w_ovf), .underflow(w_udf)
    );

    // Behavioural models of the downstream memories (registered read data).
    always @(posedge clk) begin
        if (write_en) mem[wraddr] <= wdata;
        if (read_en)  rdata <= mem[rdaddr];
        if (w_we)     mem2[w_wraddr] <= w_wdata;
        if (w_re)     rdata2 <= mem2[w_rdaddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) check("rd_valid_spurious", 32'd1, 32'd0);
            else begin
                n_rdv++;
                check("read_data", 32'(rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    // One cycle on the main instance; entered and left at posedge+1.
    task automatic cyc(input logic p, input logic q, input logic [11:0] d,
                       input logic exp_we, input logic exp_re);
        push_req = p;
        pop_req  = q;
        wdata    = d;
        #3;
        check("write_en", 32'(write_en), 32'(exp_we));
        check("read_en", 32'(read_en), 32'(exp_re));
        if (exp_we) exp_q.push_back(d);
        @(posedge clk);
        #1;
        push_req = 1'b0;
        pop_req  = 1'b0;
    endtask

    initial begin
        int exp_wr, exp_rd;
        rst_n = 1'b0; fifo_en = 1'b1; clear = 1'b0; push_req = 1'b1; pop_req = 1'b1; wdata = '0;
        w_en = 1'b1; w_clear = 1'b0; w_push = 1'b0; w_pop = 1'b0; w_wdata = '0;
        #3;
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_read_en", 32'(read_en), 32'd0);
        check("rst_wraddr", 32'(wraddr), 32'd0);
        check("rst_rdaddr", 32'(rdaddr), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_flags", {28'd0, fifofull, notempty, almost_full, rd_valid}, 32'd0);
        check("rst_err", {30'd0, overflow, underflow}, 32'd0);
        push_req = 1'b0; pop_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Five pushes then five back-to-back pops.
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 12'(i), 1'b1, 1'b0);
        check("count_5", 32'(count), 32'd5);
        check("notempty_5", 32'(notempty), 32'd1);
        n_rdv = 0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 12'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 12'h0, 1'b0, 1'b0);
        check("rd_valid_pulses", 32'(n_rdv), 32'd5);
        check("count_0", 32'(count), 32'd0);
        check("notempty_0", 32'(notempty), 32'd0);
        check("queue_empty_1", 32'(exp_q.size()), 32'd0);

        // Fill to full, watch the watermark, overflow, then full+pop.
        for (int i = 0; i < 32; i++) begin
            check("almost_full_lvl", 32'(almost_full), (i >= 28) ? 32'd1 : 32'd0);
            check("fifofull_fill", 32'(fifofull), 32'd0);
            cyc(1'b1, 1'b0, 12'h100 + 12'(i), 1'b1, 1'b0);
        end
        check("fifofull_32", 32'(fifofull), 32'd1);
        check("almost_full_32", 32'(almost_full), 32'd1);
        check("count_32", 32'(count), 32'd32);
        cyc(1'b1, 1'b0, 12'hbad, 1'b0, 1'b0);
        check("overflow", 32'(overflow), 32'(ERR));
        check("count_hold_full", 32'(count), 32'd32);
        cyc(1'b1, 1'b1, 12'hbad, 1'b0, 1'b1);
        check("count_31", 32'(count), 32'd31);
        cyc(1'b1, 1'b0, 12'h200, 1'b1, 1'b0);
        clear = 1'b1;
        cyc(1'b1, 1'b1, 12'hbad, 1'b0, 1'b0);
        clear = 1'b0;
        exp_q.delete();
        check("clear_count", 32'(count), 32'd0);
        check("clear_overflow", 32'(overflow), 32'd0);
        check("clear_ptrs", {22'd0, wraddr, rdaddr}, 32'd0);
        check("clear_flags", {28'd0, fifofull, notempty, almost_full, rd_valid}, 32'd0);

        // Push/pop contention: the write wins every cycle.
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 12'h300 + 12'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 12'h320 + 12'(i), 1'b1, 1'b0);
        check("count_24", 32'(count), 32'd24);
        for (int i = 0; i < 24; i++) cyc(1'b0, 1'b1, 12'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 12'h0, 1'b0, 1'b0);
        check("queue_empty_2", 32'(exp_q.size()), 32'd0);
        check("count_drained", 32'(count), 32'd0);

        // Empty pops: rejected, even alongside a push (no fall-through).
        cyc(1'b0, 1'b1, 12'h0, 1'b0, 1'b0);
        check("underflow", 32'(underflow), 32'(ERR));
        check("rd_valid_empty", 32'(rd_valid), 32'd0);
        cyc(1'b1, 1'b1, 12'h400, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 12'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 12'h0, 1'b0, 1'b0);
        check("queue_empty_3", 32'(exp_q.size()), 32'd0);

        // Disabled controller holds state.
        cyc(1'b1, 1'b0, 12'h500, 1'b1, 1'b0);
        fifo_en = 1'b0;
        cyc(1'b1, 1'b1, 12'hbad, 1'b0, 1'b0);
        check("disabled_count", 32'(count), 32'd1);
        check("disabled_rd_valid", 32'(rd_valid), 32'd0);
        fifo_en = 1'b1;

        // Depth-24 instance: lockstep push/pop pairs across the pointer wrap.
        exp_wr = 0;
        exp_rd = 0;
        for (int i = 0; i < 30; i++) begin
            w_push = 1'b1; w_wdata = 12'h700 + 12'(i);
            #3;
            check("wrap_wraddr", 32'(w_wraddr), 32'(exp_wr));
            check("wrap_write_en", 32'(w_we), 32'd1);
            @(posedge clk);
            #1 w_push = 1'b0; w_pop = 1'b1;
            #3;
            check("wrap_rdaddr", 32'(w_rdaddr), 32'(exp_rd));
            check("wrap_read_en", 32'(w_re), 32'd1);
            @(posedge clk);
            #1 w_pop = 1'b0;
            check("wrap_rd_valid", 32'(w_rdv), 32'd1);
            check("wrap_data", 32'(rdata2), 32'(12'h700 + 12'(i)));
            exp_wr = (exp_wr + 1) % 24;
            exp_rd = (exp_rd + 1) % 24;
        end
        check("wrap_final_wr", 32'(w_wraddr), 32'd6);
        check("wrap_final_rd", 32'(w_rdaddr), 32'd6);
        check("wrap_final_state", {25'd0, w_count, w_full, w_nempty, w_afull, w_ovf, w_udf}, 32'd0);

        // Asynchronous reset with a read in flight.
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 12'h600 + 12'(i), 1'b1, 1'b0);
        check("count_10", 32'(count), 32'd10);
        pop_req = 1'b1;
        #3 check("inflight_read_en", 32'(read_en), 32'd1);
        @(posedge clk);
        #1 check("inflight_rd_valid", 32'(rd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_ptrs", {22'd0, wraddr, rdaddr}, 32'd0);
        check("async_flags", {28'd0, fifofull, notempty, almost_full, rd_valid}, 32'd0);
        check("async_read_en", 32'(read_en), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1; pop_req = 1'b0;
        @(posedge clk);
        #1 check("post_reset_rd_valid", 32'(rd_valid), 32'd0);
        check("post_reset_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
